// File: rtl/crc_bus_host_pkg.sv
// Shared definitions for the CRC bus host: FSM state encoding, command codes
// written to the peripheral control register, and the status done-bit index.
package crc_bus_host_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CLEAR,
    WAIT_BYTE,
    WR_BYTE,
    START,
    POLL_RD,
    POLL_CHK,
    POLL_WAIT,
    RES_RD,
    RES_CAP
  } state_t;

  localparam logic [7:0]  CMD_CLEAR       = 8'hA;
  localparam logic [7:0]  CMD_START       = 8'hB;
  localparam int unsigned STATUS_DONE_BIT = 0;

endpackage

// File: rtl/crc_bus_host_if.sv
// Byte stream, peripheral register bus and result signals of the CRC bus host.
//   in_valid/in_data/in_last/in_ready : upstream byte handshake
//   bus_addr/bus_wr/bus_rd/bus_wdata  : register access strobes to the peripheral
//   bus_rdata                         : peripheral read data, valid the cycle after bus_rd
//   res_valid/res_data/res_error      : per-frame result pulse
//   busy                              : host engine active
// master = the host side, slave = the environment (upstream + peripheral + sink).
interface crc_bus_host_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic [15:0] bus_addr;
  logic        bus_wr;
  logic        bus_rd;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_error;
  logic        busy;

  modport master (
    input  in_valid, in_data, in_last, bus_rdata,
    output in_ready, bus_addr, bus_wr, bus_rd, bus_wdata,
           res_valid, res_data, res_error, busy
  );

  modport slave (
    output in_valid, in_data, in_last, bus_rdata,
    input  in_ready, bus_addr, bus_wr, bus_rd, bus_wdata,
           res_valid, res_data, res_error, busy
  );
endinterface

// File: rtl/crc_bus_host.sv
// CRC bus host: streams a byte frame into a memory-mapped CRC peripheral,
// starts the computation, polls the status register until done (or until
// TIMEOUT polls have failed) and returns the result as a one-cycle pulse.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-high reset
//   bus   : crc_bus_host_if.master (byte input, register bus, result)
module crc_bus_host
  import crc_bus_host_pkg::*;
#(
  parameter logic [15:0] IN_ADDR     = 16'h680,
  parameter logic [15:0] STATE_ADDR  = 16'h688,
  parameter logic [15:0] RESULT_ADDR = 16'h690,
  parameter logic [15:0] CTRL_ADDR   = 16'h698,
  parameter int unsigned POLL_GAP    = 8,
  parameter int unsigned TIMEOUT     = 1024
) (
  input logic            clk,
  input logic            reset,
  crc_bus_host_if.master bus
);

  // +2 keeps both counters at least one bit wide and able to hold their limit.
  localparam int unsigned PW = $clog2(TIMEOUT + 2);
  localparam int unsigned GW = $clog2(POLL_GAP + 2);

  state_t          state, nstate;
  logic [7:0]      byte_q;
  logic            last_q;
  logic [PW-1:0]   poll_cnt;
  logic [GW-1:0]   gap_cnt;
  logic            res_valid_q;
  logic            res_error_q;
  logic [31:0]     res_data_q;

  logic [PW-1:0]   poll_next;
  logic [GW-1:0]   gap_next;
  logic            status_done;
  logic            poll_expired;
  logic            gap_done;

  assign poll_next    = poll_cnt + PW'(1);
  assign gap_next     = gap_cnt + GW'(1);
  assign status_done  = bus.bus_rdata[STATUS_DONE_BIT];
  // poll_cnt never exceeds TIMEOUT: reaching it leaves the poll loop.
  assign poll_expired = (poll_next >= PW'(TIMEOUT));
  assign gap_done     = (gap_next >= GW'(POLL_GAP));

  assign bus.res_valid = res_valid_q;
  assign bus.res_error = res_error_q;
  assign bus.res_data  = res_data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      byte_q      <= '0;
      last_q      <= 1'b0;
      poll_cnt    <= '0;
      gap_cnt     <= '0;
      res_valid_q <= 1'b0;
      res_error_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state       <= nstate;
      res_valid_q <= 1'b0;
      res_error_q <= 1'b0;
      case (state)
        WAIT_BYTE: begin
          if (bus.in_valid) begin
            byte_q <= bus.in_data;
            last_q <= bus.in_last;
          end
        end
        START: begin
          poll_cnt <= '0;
          gap_cnt  <= '0;
        end
        POLL_CHK: begin
          gap_cnt <= '0;
          if (!status_done) begin
            poll_cnt <= poll_next;
            if (poll_expired) begin
              res_valid_q <= 1'b1;
              res_error_q <= 1'b1;
              res_data_q  <= '0;
            end
          end
        end
        POLL_WAIT: gap_cnt <= gap_next;
        RES_CAP: begin
          res_valid_q <= 1'b1;
          res_data_q  <= bus.bus_rdata;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nstate        = state;
    bus.in_ready  = 1'b0;
    bus.bus_addr  = '0;
    bus.bus_wr    = 1'b0;
    bus.bus_rd    = 1'b0;
    bus.bus_wdata = '0;
    bus.busy      = (state != IDLE);
    case (state)
      IDLE: if (bus.in_valid) nstate = CLEAR;
      CLEAR: begin
        bus.bus_wr    = 1'b1;
        bus.bus_addr  = CTRL_ADDR;
        bus.bus_wdata = {24'h0, CMD_CLEAR};
        nstate        = WAIT_BYTE;
      end
      WAIT_BYTE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) nstate = WR_BYTE;
      end
      WR_BYTE: begin
        bus.bus_wr    = 1'b1;
        bus.bus_addr  = IN_ADDR;
        bus.bus_wdata = {24'h0, byte_q};
        nstate        = last_q ? START : WAIT_BYTE;
      end
      START: begin
        bus.bus_wr    = 1'b1;
        bus.bus_addr  = CTRL_ADDR;
        bus.bus_wdata = {24'h0, CMD_START};
        nstate        = POLL_RD;
      end
      POLL_RD: begin
        bus.bus_rd   = 1'b1;
        bus.bus_addr = STATE_ADDR;
        nstate       = POLL_CHK;
      end
      POLL_CHK: begin
        if (status_done)       nstate = RES_RD;
        else if (poll_expired) nstate = IDLE;
        else if (POLL_GAP == 0) nstate = POLL_RD;
        else                   nstate = POLL_WAIT;
      end
      POLL_WAIT: if (gap_done) nstate = POLL_RD;
      RES_RD: begin
        bus.bus_rd   = 1'b1;
        bus.bus_addr = RESULT_ADDR;
        nstate       = RES_CAP;
      end
      RES_CAP: nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

endmodule
